// File: rtl/dual_port_mem.sv
// Shared-array memory model with an instruction-fetch read port and a data load/store port.
// Each port has an RD_LAT-deep response pipeline; faulted requests are counted in a saturating counter.
module dual_port_mem #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INST_W = 32,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned FCNT_W = 16
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_valid,
  output logic [INST_W-1:0]   i_rdata,
  output logic                i_fault,
  input  logic                d_req,
  input  logic                d_wr_en,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wmask,
  output logic                d_valid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_fault,
  output logic [FCNT_W-1:0]   fault_cnt
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned WB    = $clog2(NB);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned SH_W  = WB + 3;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              i_vld_q [RD_LAT];
  logic              i_flt_q [RD_LAT];
  logic [INST_W-1:0] i_dat_q [RD_LAT];
  logic              d_vld_q [RD_LAT];
  logic              d_flt_q [RD_LAT];
  logic [DATA_W-1:0] d_dat_q [RD_LAT];
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic [ADDR_W-1:0] i_widx, d_widx;
  logic [DATA_W-1:0] i_word, d_word;
  logic [SH_W-1:0]   i_shamt;
  logic              i_flt_c, d_flt_c;
  logic [INST_W-1:0] i_dat_c;
  logic [DATA_W-1:0] d_dat_c;
  logic [1:0]        inc_c;
  logic [FCNT_W:0]   sum_c;

  // Request decode and array read; the read sees pre-write contents (read-before-write).
  always_comb begin
    i_widx  = i_addr >> WB;
    d_widx  = d_addr >> WB;
    i_word  = mem_q[i_widx[IDX_W-1:0]];
    d_word  = mem_q[d_widx[IDX_W-1:0]];
    i_shamt = {i_addr[WB-1:0], 3'b000};
    i_flt_c = (i_addr[1:0] != 2'b00) || (i_widx >= ADDR_W'(DEPTH));
    d_flt_c = (d_widx >= ADDR_W'(DEPTH));
    i_dat_c = i_flt_c ? '0 : INST_W'(i_word >> i_shamt);
    d_dat_c = (d_wr_en || d_flt_c) ? '0 : d_word;
  end

  // Saturating fault counter next-state.
  always_comb begin
    fcnt_d = fcnt_q;
    inc_c  = 2'(i_req && i_flt_c) + 2'(d_req && d_flt_c);
    sum_c  = (FCNT_W+1)'(fcnt_q) + (FCNT_W+1)'(inc_c);
    fcnt_d = sum_c[FCNT_W] ? '1 : sum_c[FCNT_W-1:0];
  end

  // Byte-masked store; gated by nrst so requests held during reset never write.
  always_ff @(posedge clk) begin
    if (nrst && d_req && d_wr_en && !d_flt_c) begin
      for (int k = 0; k < int'(NB); k++) begin
        if (d_wmask[k]) mem_q[d_widx[IDX_W-1:0]][8*k +: 8] <= d_wdata[8*k +: 8];
      end
    end
  end

  // Response pipelines and counter; reset flushes everything in flight.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int s = 0; s < int'(RD_LAT); s++) begin
        i_vld_q[s] <= 1'b0;
        i_flt_q[s] <= 1'b0;
        i_dat_q[s] <= '0;
        d_vld_q[s] <= 1'b0;
        d_flt_q[s] <= 1'b0;
        d_dat_q[s] <= '0;
      end
      fcnt_q <= '0;
    end else begin
      i_vld_q[0] <= i_req;
      i_flt_q[0] <= i_req && i_flt_c;
      i_dat_q[0] <= i_req ? i_dat_c : '0;
      d_vld_q[0] <= d_req;
      d_flt_q[0] <= d_req && d_flt_c;
      d_dat_q[0] <= d_req ? d_dat_c : '0;
      for (int s = 1; s < int'(RD_LAT); s++) begin
        i_vld_q[s] <= i_vld_q[s-1];
        i_flt_q[s] <= i_flt_q[s-1];
        i_dat_q[s] <= i_dat_q[s-1];
        d_vld_q[s] <= d_vld_q[s-1];
        d_flt_q[s] <= d_flt_q[s-1];
        d_dat_q[s] <= d_dat_q[s-1];
      end
      fcnt_q <= fcnt_d;
    end
  end

  assign i_valid   = i_vld_q[RD_LAT-1];
  assign i_fault   = i_flt_q[RD_LAT-1];
  assign i_rdata   = i_dat_q[RD_LAT-1];
  assign d_valid   = d_vld_q[RD_LAT-1];
  assign d_fault   = d_flt_q[RD_LAT-1];
  assign d_rdata   = d_dat_q[RD_LAT-1];
  assign fault_cnt = fcnt_q;

endmodule

// File: tb/tb_dual_port_mem.sv
// Scoreboard bench for dual_port_mem: stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_dual_port_mem;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned DEPTH  = 512;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned FCNT_W = 4;
  localparam logic [FCNT_W-1:0] FMAX = '1;

  logic                clk, nrst;
  logic                i_req, i_valid, i_fault;
  logic [ADDR_W-1:0]   i_addr;
  logic [INST_W-1:0]   i_rdata;
  logic                d_req, d_wr_en, d_valid, d_fault;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata, d_rdata;
  logic [DATA_W/8-1:0] d_wmask;
  logic [FCNT_W-1:0]   fault_cnt;

  dual_port_mem #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .INST_W(INST_W), .RD_LAT(RD_LAT), .FCNT_W(FCNT_W)
  ) dut (
    .clk(clk), .nrst(nrst),
    .i_req(i_req), .i_addr(i_addr), .i_valid(i_valid), .i_rdata(i_rdata), .i_fault(i_fault),
    .d_req(d_req), .d_wr_en(d_wr_en), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_valid(d_valid), .d_rdata(d_rdata), .d_fault(d_fault), .fault_cnt(fault_cnt)
  );

  typedef struct {
    logic        flt;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t iq[$];
  exp_t dq[$];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [FCNT_W-1:0] exp_fcnt = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  // Monitor: every valid response is matched against the oldest expectation for that port.
  always @(negedge clk) begin
    exp_t e;
    if (i_valid) begin
      if (iq.size() == 0) chk("i_unexpected_valid", 64'(i_rdata), 64'hDEAD);
      else begin
        e = iq.pop_front();
        chk("i_latency", 64'(cyc), 64'(e.cyc));
        chk("i_fault", 64'(i_fault), 64'(e.flt));
        chk("i_rdata", 64'(i_rdata), e.data);
      end
    end
    if (d_valid) begin
      if (dq.size() == 0) chk("d_unexpected_valid", d_rdata, 64'hDEAD);
      else begin
        e = dq.pop_front();
        chk("d_latency", 64'(cyc), 64'(e.cyc));
        chk("d_fault", 64'(d_fault), 64'(e.flt));
        chk("d_rdata", d_rdata, e.data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req = 1'b0;
    d_req = 1'b0;
    d_wr_en = 1'b0;
  endtask

  task automatic bump_fcnt();
    if (exp_fcnt != FMAX) exp_fcnt = exp_fcnt + FCNT_W'(1);
  endtask

  task automatic d_op(input logic wr, input logic [31:0] addr, input logic [63:0] wdata,
                      input logic [7:0] mask, input logic eflt, input logic [63:0] edata);
    exp_t e;
    d_req = 1'b1; d_wr_en = wr; d_addr = addr; d_wdata = wdata; d_wmask = mask;
    e.flt = eflt; e.data = edata; e.cyc = cyc + int'(RD_LAT);
    dq.push_back(e);
    if (eflt) bump_fcnt();
  endtask

  task automatic i_op(input logic [31:0] addr, input logic eflt, input logic [31:0] edata);
    exp_t e;
    i_req = 1'b1; i_addr = addr;
    e.flt = eflt; e.data = 64'(edata); e.cyc = cyc + int'(RD_LAT);
    iq.push_back(e);
    if (eflt) bump_fcnt();
  endtask

  task automatic drain();
    idle();
    repeat (RD_LAT + 2) step();
  endtask

  initial begin
    idle();
    i_addr = '0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    nrst = 1'b0;
    repeat (3) step();
    chk("rst_i_valid", 64'(i_valid), 64'd0);
    chk("rst_d_valid", 64'(d_valid), 64'd0);
    chk("rst_d_rdata", d_rdata, 64'd0);
    chk("rst_fault_cnt", 64'(fault_cnt), 64'd0);
    nrst = 1'b1;
    step();

    // Store then load, plus a marker in word 0 to catch wrapped out-of-range writes.
    d_op(1'b1, 32'h0, 64'hDEADBEEFCAFEF00D, 8'hFF, 1'b0, 64'h0); step();
    d_op(1'b1, 32'h20, 64'h1122334455667788, 8'hFF, 1'b0, 64'h0); step();
    d_op(1'b0, 32'h20, 64'h0, 8'h00, 1'b0, 64'h1122334455667788); step();
    drain();

    // Byte-masked store.
    d_op(1'b1, 32'h20, 64'hAAAAAAAABBBBBBBB, 8'h0F, 1'b0, 64'h0); step();
    d_op(1'b0, 32'h20, 64'h0, 8'h00, 1'b0, 64'h11223344BBBBBBBB); step();
    drain();

    // Fetch lanes and misalignment.
    i_op(32'h24, 1'b0, 32'h11223344); step();
    i_op(32'h20, 1'b0, 32'hBBBBBBBB); step();
    i_op(32'h22, 1'b1, 32'h0); step();
    idle();
    chk("fcnt_misalign", 64'(fault_cnt), 64'(exp_fcnt));
    drain();

    // Range faults on both ports in one edge; the faulted store must not write.
    d_op(1'b1, 32'h1000, 64'h5555555555555555, 8'hFF, 1'b1, 64'h0);
    i_op(32'h1000, 1'b1, 32'h0);
    step();
    idle();
    chk("fcnt_dual_fault", 64'(fault_cnt), 64'(exp_fcnt));
    d_op(1'b0, 32'h20, 64'h0, 8'h00, 1'b0, 64'h11223344BBBBBBBB); step();
    d_op(1'b0, 32'h0, 64'h0, 8'h00, 1'b0, 64'hDEADBEEFCAFEF00D); step();
    d_op(1'b0, 32'hFF8, 64'h0, 8'h00, 1'b0, 64'hX); idle();
    dq.pop_back();
    drain();

    // Saturation: keep faulting on both ports past all-ones.
    for (int n = 0; n < 8; n++) begin
      d_op(1'b0, 32'h2000, 64'h0, 8'h00, 1'b1, 64'h0);
      i_op(32'h1001, 1'b1, 32'h0);
      step();
    end
    idle();
    chk("fcnt_saturated", 64'(fault_cnt), 64'(FMAX));
    drain();
    chk("fcnt_still_sat", 64'(fault_cnt), 64'(exp_fcnt));

    // Streaming: four back-to-back loads.
    for (int n = 0; n < 4; n++) begin
      d_op(1'b1, 32'h40 + 32'(8*n), 64'h0101010101010101 * 64'(n + 1), 8'hFF, 1'b0, 64'h0); step();
    end
    for (int n = 0; n < 4; n++) begin
      d_op(1'b0, 32'h40 + 32'(8*n), 64'h0, 8'h00, 1'b0, 64'h0101010101010101 * 64'(n + 1)); step();
    end
    drain();

    // Reset with two loads in flight: both dropped, a store held during reset is ignored.
    d_op(1'b0, 32'h40, 64'h0, 8'h00, 1'b0, 64'h0101010101010101); step();
    d_op(1'b0, 32'h48, 64'h0, 8'h00, 1'b0, 64'h0202020202020202); step();
    idle();
    nrst = 1'b0;
    dq.delete();
    exp_fcnt = '0;
    #1;
    chk("rst_inflight_d_valid", 64'(d_valid), 64'd0);
    chk("rst_inflight_d_rdata", d_rdata, 64'd0);
    chk("rst_inflight_fcnt", 64'(fault_cnt), 64'd0);
    d_req = 1'b1; d_wr_en = 1'b1; d_addr = 32'h40; d_wdata = 64'hFFFF0000FFFF0000; d_wmask = 8'hFF;
    i_req = 1'b1; i_addr = 32'h1002;
    step();
    step();
    idle();
    nrst = 1'b1;
    repeat (RD_LAT + 3) step();
    chk("post_rst_fcnt", 64'(fault_cnt), 64'd0);
    d_op(1'b0, 32'h40, 64'h0, 8'h00, 1'b0, 64'h0101010101010101); step();
    drain();

    // Same-cycle store and fetch to one word: fetch sees old data, later fetches see new.
    d_op(1'b1, 32'h20, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 1'b0, 64'h0);
    i_op(32'h20, 1'b0, 32'hBBBBBBBB);
    step();
    idle();
    i_op(32'h20, 1'b0, 32'hFFFFFFFF); step();
    i_op(32'h24, 1'b0, 32'hFFFFFFFF); step();
    drain();

    chk("i_queue_empty", 64'(iq.size()), 64'd0);
    chk("d_queue_empty", 64'(dq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
